// File: rtl/axi_mem_arb_pkg.sv
// Shared types and constants for the two-port SRAM arbiter: port encoding,
// the request bundle that is muxed onto the macro, and burst-length legality.
package axi_mem_arb_pkg;

  localparam logic PORT_WR = 1'b0;
  localparam logic PORT_RD = 1'b1;

  localparam int ARB_ADDR_W = 16;
  localparam int ARB_DATA_W = 64;
  localparam int ARB_BE_W   = ARB_DATA_W / 8;

  localparam int MAX_BURST_MIN = 1;
  localparam int MAX_BURST_MAX = 255;

  typedef struct packed {
    logic                  cen;
    logic                  wen;
    logic [ARB_ADDR_W-1:0] a;
    logic [ARB_DATA_W-1:0] d;
    logic [ARB_BE_W-1:0]   be;
  } mem_req_t;

  function automatic bit max_burst_legal(input int mb);
    return (mb >= MAX_BURST_MIN) && (mb <= MAX_BURST_MAX);
  endfunction

endpackage

// File: rtl/arb_burst_rr2.sv
// Two-way round-robin arbiter that lets the current owner keep the port for
// at most MAX_BURST consecutive grants while the other side is waiting.
module arb_burst_rr2
  import axi_mem_arb_pkg::*;
#(
  parameter int MAX_BURST = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  output logic [1:0] gnt
);

  localparam logic [7:0] BURST_LAST = 8'(MAX_BURST - 1);

  if (!max_burst_legal(MAX_BURST)) begin : g_burst_check
    $error("arb_burst_rr2: MAX_BURST out of range 1..255");
  end

  logic       owner_q, owner_d;
  logic [7:0] cnt_q, cnt_d;
  logic       gnt_port;

  // Grant: owner wins contention, a lone requester always wins, reset blocks all.
  always_comb begin
    gnt = 2'b00;
    if (!rst_n) begin
      gnt = 2'b00;
    end else if (req == 2'b11) begin
      gnt = (owner_q == PORT_RD) ? 2'b10 : 2'b01;
    end else begin
      gnt = req;
    end
  end

  // Burst bookkeeping: ownership flips once the owner has used its allowance.
  always_comb begin
    owner_d  = owner_q;
    cnt_d    = cnt_q;
    gnt_port = gnt[1];
    if (gnt != 2'b00) begin
      if (gnt_port == owner_q) begin
        if (cnt_q == BURST_LAST) begin
          owner_d = ~gnt_port;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end else if (MAX_BURST == 1) begin
        owner_d = ~gnt_port;
        cnt_d   = 8'd0;
      end else begin
        owner_d = gnt_port;
        cnt_d   = 8'd1;
      end
    end else begin
      owner_d = owner_q;
      cnt_d   = cnt_q;
    end
  end

  // State register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      owner_q <= PORT_WR;
      cnt_q   <= 8'd0;
    end else begin
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/axi_mem_rw_arbiter.sv
// Merges the write-controller and read-controller SRAM ports onto one macro
// port and steers the 1-cycle-latency read data back to the issuing port.
module axi_mem_rw_arbiter
  import axi_mem_arb_pkg::*;
#(
  parameter int MEM_ADDR_WIDTH = 16,
  parameter int DATA_WIDTH     = 64,
  parameter int BE_WIDTH       = DATA_WIDTH / 8,
  parameter int MAX_BURST      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      wr_valid_i,
  input  logic                      wr_CEN_i,
  input  logic                      wr_WEN_i,
  input  logic [MEM_ADDR_WIDTH-1:0] wr_A_i,
  input  logic [DATA_WIDTH-1:0]     wr_D_i,
  input  logic [BE_WIDTH-1:0]       wr_BE_i,
  output logic                      wr_grant_o,
  output logic [DATA_WIDTH-1:0]     wr_Q_o,
  output logic                      wr_rvalid_o,
  input  logic                      rd_valid_i,
  input  logic                      rd_CEN_i,
  input  logic                      rd_WEN_i,
  input  logic [MEM_ADDR_WIDTH-1:0] rd_A_i,
  input  logic [DATA_WIDTH-1:0]     rd_D_i,
  input  logic [BE_WIDTH-1:0]       rd_BE_i,
  output logic                      rd_grant_o,
  output logic [DATA_WIDTH-1:0]     rd_Q_o,
  output logic                      rd_rvalid_o,
  output logic                      MEM_CEN_o,
  output logic                      MEM_WEN_o,
  output logic [MEM_ADDR_WIDTH-1:0] MEM_A_o,
  output logic [DATA_WIDTH-1:0]     MEM_D_o,
  output logic [BE_WIDTH-1:0]       MEM_BE_o,
  input  logic [DATA_WIDTH-1:0]     MEM_Q_i
);

  if (MEM_ADDR_WIDTH != ARB_ADDR_W || DATA_WIDTH != ARB_DATA_W || BE_WIDTH != ARB_BE_W)
  begin : g_width_check
    $error("axi_mem_rw_arbiter: widths must match axi_mem_arb_pkg request type");
  end

  mem_req_t   wr_req, rd_req, mem_req;
  logic [1:0] req, gnt;
  logic       rvalid_q, rvalid_d;
  logic       rsel_q, rsel_d;

  assign wr_req = '{cen: wr_CEN_i, wen: wr_WEN_i, a: wr_A_i, d: wr_D_i, be: wr_BE_i};
  assign rd_req = '{cen: rd_CEN_i, wen: rd_WEN_i, a: rd_A_i, d: rd_D_i, be: rd_BE_i};

  assign req[PORT_WR] = wr_valid_i & ~wr_CEN_i;
  assign req[PORT_RD] = rd_valid_i & ~rd_CEN_i;

  arb_burst_rr2 #(
    .MAX_BURST (MAX_BURST)
  ) u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .gnt   (gnt)
  );

  assign wr_grant_o = gnt[PORT_WR];
  assign rd_grant_o = gnt[PORT_RD];

  // Macro-side mux; an idle port parks on a deselected read with zeroed buses.
  always_comb begin
    mem_req = '{cen: 1'b1, wen: 1'b1, a: '0, d: '0, be: '0};
    if (gnt[PORT_WR]) begin
      mem_req     = wr_req;
      mem_req.cen = 1'b0;
    end else if (gnt[PORT_RD]) begin
      mem_req     = rd_req;
      mem_req.cen = 1'b0;
    end else begin
      mem_req = '{cen: 1'b1, wen: 1'b1, a: '0, d: '0, be: '0};
    end
  end

  assign MEM_CEN_o = mem_req.cen;
  assign MEM_WEN_o = mem_req.wen;
  assign MEM_A_o   = mem_req.a;
  assign MEM_D_o   = mem_req.d;
  assign MEM_BE_o  = mem_req.be;

  // Remember which port issued a granted read so the return is qualified for it.
  always_comb begin
    rvalid_d = (gnt != 2'b00) & mem_req.wen;
    rsel_d   = rsel_q;
    if (rvalid_d) begin
      rsel_d = gnt[PORT_RD];
    end else begin
      rsel_d = rsel_q;
    end
  end

  // Read-return registers; reset drops any return still in flight.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rvalid_q <= 1'b0;
      rsel_q   <= PORT_WR;
    end else begin
      rvalid_q <= rvalid_d;
      rsel_q   <= rsel_d;
    end
  end

  assign wr_rvalid_o = rvalid_q & (rsel_q == PORT_WR);
  assign rd_rvalid_o = rvalid_q & (rsel_q == PORT_RD);
  assign wr_Q_o      = MEM_Q_i;
  assign rd_Q_o      = MEM_Q_i;

endmodule

// File: tb/tb_axi_mem_rw_arbiter.sv
// Directed bench: two arbiters (MAX_BURST 4 and 1) on shared stimulus, a
// behavioural SRAM behind the first, and a scoreboard of read returns.
module tb_axi_mem_rw_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wr_valid_i, wr_CEN_i, wr_WEN_i;
  logic [15:0] wr_A_i;
  logic [63:0] wr_D_i;
  logic [7:0]  wr_BE_i;
  logic        rd_valid_i, rd_CEN_i, rd_WEN_i;
  logic [15:0] rd_A_i;
  logic [63:0] rd_D_i;
  logic [7:0]  rd_BE_i;

  logic        wr_grant_o, wr_rvalid_o, rd_grant_o, rd_rvalid_o;
  logic [63:0] wr_Q_o, rd_Q_o;
  logic        MEM_CEN_o, MEM_WEN_o;
  logic [15:0] MEM_A_o;
  logic [63:0] MEM_D_o, MEM_Q_i;
  logic [7:0]  MEM_BE_o;

  logic        b_wr_grant, b_wr_rvalid, b_rd_grant, b_rd_rvalid;
  logic [63:0] b_wr_Q, b_rd_Q;
  logic        b_CEN, b_WEN;
  logic [15:0] b_A;
  logic [63:0] b_D;
  logic [7:0]  b_BE;
  logic [63:0] b_mem_q;

  logic [63:0] mem_arr [0:1023];
  logic [63:0] shadow  [0:1023];

  typedef struct {
    logic        wv;
    logic        rv;
    logic [63:0] q;
  } exp_t;
  exp_t sbq[$];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  always #5 clk = ~clk;
  assign b_mem_q = 64'd0;

  axi_mem_rw_arbiter #(.MAX_BURST(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .wr_valid_i(wr_valid_i), .wr_CEN_i(wr_CEN_i), .wr_WEN_i(wr_WEN_i),
    .wr_A_i(wr_A_i), .wr_D_i(wr_D_i), .wr_BE_i(wr_BE_i),
    .wr_grant_o(wr_grant_o), .wr_Q_o(wr_Q_o), .wr_rvalid_o(wr_rvalid_o),
    .rd_valid_i(rd_valid_i), .rd_CEN_i(rd_CEN_i), .rd_WEN_i(rd_WEN_i),
    .rd_A_i(rd_A_i), .rd_D_i(rd_D_i), .rd_BE_i(rd_BE_i),
    .rd_grant_o(rd_grant_o), .rd_Q_o(rd_Q_o), .rd_rvalid_o(rd_rvalid_o),
    .MEM_CEN_o(MEM_CEN_o), .MEM_WEN_o(MEM_WEN_o), .MEM_A_o(MEM_A_o),
    .MEM_D_o(MEM_D_o), .MEM_BE_o(MEM_BE_o), .MEM_Q_i(MEM_Q_i)
  );

  axi_mem_rw_arbiter #(.MAX_BURST(1)) dut_b1 (
    .clk(clk), .rst_n(rst_n),
    .wr_valid_i(wr_valid_i), .wr_CEN_i(wr_CEN_i), .wr_WEN_i(wr_WEN_i),
    .wr_A_i(wr_A_i), .wr_D_i(wr_D_i), .wr_BE_i(wr_BE_i),
    .wr_grant_o(b_wr_grant), .wr_Q_o(b_wr_Q), .wr_rvalid_o(b_wr_rvalid),
    .rd_valid_i(rd_valid_i), .rd_CEN_i(rd_CEN_i), .rd_WEN_i(rd_WEN_i),
    .rd_A_i(rd_A_i), .rd_D_i(rd_D_i), .rd_BE_i(rd_BE_i),
    .rd_grant_o(b_rd_grant), .rd_Q_o(b_rd_Q), .rd_rvalid_o(b_rd_rvalid),
    .MEM_CEN_o(b_CEN), .MEM_WEN_o(b_WEN), .MEM_A_o(b_A),
    .MEM_D_o(b_D), .MEM_BE_o(b_BE), .MEM_Q_i(b_mem_q)
  );

  // Behavioural SRAM with byte enables and one cycle of read latency.
  always @(posedge clk) begin
    if (!MEM_CEN_o) begin
      if (!MEM_WEN_o) begin
        for (int b = 0; b < 8; b++)
          if (MEM_BE_o[b]) mem_arr[MEM_A_o[9:0]][b*8 +: 8] <= MEM_D_o[b*8 +: 8];
      end else begin
        MEM_Q_i <= mem_arr[MEM_A_o[9:0]];
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s@%0d observed=%h expected=%h", tag, cyc, obs, exp);
    end
  endtask

  task automatic drv_wr(input logic v, c, w, input logic [15:0] a, input logic [63:0] d,
                        input logic [7:0] be);
    wr_valid_i = v; wr_CEN_i = c; wr_WEN_i = w; wr_A_i = a; wr_D_i = d; wr_BE_i = be;
  endtask

  task automatic drv_rd(input logic v, c, w, input logic [15:0] a, input logic [63:0] d,
                        input logic [7:0] be);
    rd_valid_i = v; rd_CEN_i = c; rd_WEN_i = w; rd_A_i = a; rd_D_i = d; rd_BE_i = be;
  endtask

  task automatic shadow_write(input logic [15:0] a, input logic [63:0] d, input logic [7:0] be);
    for (int b = 0; b < 8; b++)
      if (be[b]) shadow[a[9:0]][b*8 +: 8] = d[b*8 +: 8];
  endtask

  // One cycle, entered just after a falling edge with inputs already driven.
  task automatic step(input logic ewg, erg, ebw, ebr);
    exp_t        e;
    logic [15:0] ra;
    e = sbq.pop_front();
    chk("wr_rvalid", {63'd0, wr_rvalid_o}, {63'd0, e.wv});
    chk("rd_rvalid", {63'd0, rd_rvalid_o}, {63'd0, e.rv});
    if (e.wv || e.rv) begin
      chk("wr_Q", wr_Q_o, e.q);
      chk("rd_Q", rd_Q_o, e.q);
    end
    #1;
    chk("wr_grant", {63'd0, wr_grant_o}, {63'd0, ewg});
    chk("rd_grant", {63'd0, rd_grant_o}, {63'd0, erg});
    chk("mem_cen", {63'd0, MEM_CEN_o}, {63'd0, ~(ewg | erg)});
    chk("b1_wr_grant", {63'd0, b_wr_grant}, {63'd0, ebw});
    chk("b1_rd_grant", {63'd0, b_rd_grant}, {63'd0, ebr});
    chk("b1_mem_cen", {63'd0, b_CEN}, {63'd0, ~(ebw | ebr)});
    if (ewg) begin
      chk("mem_wen", {63'd0, MEM_WEN_o}, {63'd0, wr_WEN_i});
      chk("mem_a", {48'd0, MEM_A_o}, {48'd0, wr_A_i});
      chk("mem_d", MEM_D_o, wr_D_i);
      chk("mem_be", {56'd0, MEM_BE_o}, {56'd0, wr_BE_i});
    end else if (erg) begin
      chk("mem_wen", {63'd0, MEM_WEN_o}, {63'd0, rd_WEN_i});
      chk("mem_a", {48'd0, MEM_A_o}, {48'd0, rd_A_i});
      chk("mem_d", MEM_D_o, rd_D_i);
      chk("mem_be", {56'd0, MEM_BE_o}, {56'd0, rd_BE_i});
    end else begin
      chk("mem_wen_idle", {63'd0, MEM_WEN_o}, 64'd1);
      chk("mem_a_idle", {48'd0, MEM_A_o}, 64'd0);
      chk("mem_d_idle", MEM_D_o, 64'd0);
      chk("mem_be_idle", {56'd0, MEM_BE_o}, 64'd0);
    end
    e.wv = ewg & wr_WEN_i;
    e.rv = erg & rd_WEN_i;
    ra   = ewg ? wr_A_i : rd_A_i;
    e.q  = shadow[ra[9:0]];
    if (ewg && !wr_WEN_i) shadow_write(wr_A_i, wr_D_i, wr_BE_i);
    if (erg && !rd_WEN_i) shadow_write(rd_A_i, rd_D_i, rd_BE_i);
    sbq.push_back(e);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  initial begin
    rst_n = 1'b0;
    drv_wr(1'b0, 1'b1, 1'b1, 16'd0, 64'd0, 8'd0);
    drv_rd(1'b0, 1'b1, 1'b1, 16'd0, 64'd0, 8'd0);
    sbq.push_back('{1'b0, 1'b0, 64'd0});
    @(negedge clk);

    // Reset forces grants low even with both ports requesting.
    drv_wr(1'b1, 1'b0, 1'b0, 16'h0010, 64'd5, 8'hFF);
    drv_rd(1'b1, 1'b0, 1'b1, 16'h0010, 64'd0, 8'h00);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Lone writer streams; rd valid with CEN high must be ignored.
    drv_rd(1'b1, 1'b1, 1'b1, 16'h0033, 64'd0, 8'h00);
    for (int i = 0; i < 10; i++) begin
      drv_wr(1'b1, 1'b0, 1'b0, 16'h0010 + 16'(i), {32'hC0DE_0000 + 32'(i), 32'h5A5A_0000 + 32'(i)}, 8'hFF);
      step(1'b1, 1'b0, 1'b1, 1'b0);
    end

    drv_wr(1'b0, 1'b1, 1'b1, 16'd0, 64'd0, 8'd0);
    drv_rd(1'b0, 1'b1, 1'b1, 16'd0, 64'd0, 8'd0);
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Contention: blocks of four on the MAX_BURST=4 arbiter, alternation on the other.
    for (int i = 0; i < 16; i++) begin
      drv_wr(1'b1, 1'b0, 1'b0, 16'h0100 + 16'(i), 64'h0101_0101_0101_0101 * 64'(i + 1), 8'hFF);
      drv_rd(1'b1, 1'b0, 1'b1, 16'h0010 + 16'(i % 10), 64'd0, 8'h00);
      step(((i / 4) % 2) == 0, ((i / 4) % 2) == 1, (i % 2) == 0, (i % 2) == 1);
    end

    drv_wr(1'b0, 1'b1, 1'b1, 16'd0, 64'd0, 8'd0);
    drv_rd(1'b0, 1'b1, 1'b1, 16'd0, 64'd0, 8'd0);
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Full write then read-back through the rd port.
    drv_wr(1'b1, 1'b0, 1'b0, 16'h0040, 64'hDEADBEEF_CAFE0000, 8'hFF);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    drv_wr(1'b0, 1'b1, 1'b1, 16'd0, 64'd0, 8'd0);
    drv_rd(1'b1, 1'b0, 1'b1, 16'h0040, 64'd0, 8'h00);
    step(1'b0, 1'b1, 1'b0, 1'b1);
    drv_rd(1'b0, 1'b1, 1'b1, 16'd0, 64'd0, 8'd0);
    chk("rd_rvalid_after_read", {63'd0, rd_rvalid_o}, 64'd1);
    chk("wr_rvalid_after_rd_read", {63'd0, wr_rvalid_o}, 64'd0);
    chk("rd_Q_deadbeef", rd_Q_o, 64'hDEADBEEF_CAFE0000);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    // Byte-enabled partial write, read back through the wr port.
    drv_wr(1'b1, 1'b0, 1'b0, 16'h0041, 64'hAAAAAAAA_BBBBBBBB, 8'hFF);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    drv_wr(1'b1, 1'b0, 1'b0, 16'h0041, 64'h11111111_22222222, 8'h0F);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    drv_wr(1'b1, 1'b0, 1'b1, 16'h0041, 64'd0, 8'h00);
    step(1'b1, 1'b0, 1'b1, 1'b0);
    drv_wr(1'b0, 1'b1, 1'b1, 16'd0, 64'd0, 8'd0);
    chk("wr_rvalid_after_read", {63'd0, wr_rvalid_o}, 64'd1);
    chk("rd_rvalid_after_wr_read", {63'd0, rd_rvalid_o}, 64'd0);
    chk("wr_Q_partial", wr_Q_o, 64'hAAAAAAAA_22222222);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;

    // Reset lands in the third RD cycle of a burst with a read in flight.
    for (int i = 0; i < 6; i++) begin
      drv_wr(1'b1, 1'b0, 1'b0, 16'h0200 + 16'(i), 64'h7777_0000_0000_0000 + 64'(i), 8'hFF);
      drv_rd(1'b1, 1'b0, 1'b1, 16'h0010, 64'd0, 8'h00);
      step(i < 4, i >= 4, (i % 2) == 0, (i % 2) == 1);
    end
    rst_n = 1'b0;
    step(1'b0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    step(1'b1, 1'b0, 1'b1, 1'b0);
    drv_wr(1'b0, 1'b1, 1'b1, 16'd0, 64'd0, 8'd0);
    drv_rd(1'b0, 1'b1, 1'b1, 16'd0, 64'd0, 8'd0);
    step(1'b0, 1'b0, 1'b0, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
